// File: rtl/cpu6502_alu_sequencer.sv
// Multicycle fetch/decode/execute sequencer for the 6502 group-one opcode
// subset (ORA/AND/EOR/ADC/STA/LDA/CMP in immediate, zero-page and absolute
// modes). The arithmetic is done by an external combinational ALU; this block
// owns the architectural state and the memory handshake.
module cpu6502_alu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0200
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [4:0]  alu_operation,
  output logic [7:0]  alu_operand1,
  output logic [7:0]  alu_operand2,
  output logic        alu_carry_in,
  input  logic [7:0]  alu_result,
  input  logic        alu_carry_out,
  output logic [7:0]  reg_a,
  output logic        flag_c,
  output logic        flag_z,
  output logic        flag_n,
  output logic [15:0] pc,
  output logic        halted
);

  typedef enum logic [2:0] {
    FETCH_OP,
    FETCH_LO,
    FETCH_HI,
    READ_OPND,
    EXECUTE,
    WRITE,
    HALT
  } state_t;

  state_t      state_reg, state_next;
  // Cleared by reset so the cycle right after a reset edge never requests,
  // which also makes a stray ack in that cycle harmless.
  logic        run_reg;
  logic [15:0] pc_reg, pc_next;
  logic [7:0]  a_reg, a_next;
  logic [7:0]  opcode_reg, opcode_next;
  logic [7:0]  operand_reg, operand_next;
  logic [7:0]  lo_reg, lo_next;
  logic [7:0]  hi_reg, hi_next;
  logic        c_reg, c_next;
  logic        z_reg, z_next;
  logic        n_reg, n_next;

  logic        xfer_done;
  logic [2:0]  bbb;
  logic        is_sta;
  logic        is_cmp;
  logic [7:0]  cmp_diff;
  logic [15:0] eff_addr;

  // Anything outside the supported group-one subset stops the machine;
  // 8'h89 would be "STA immediate", which has no meaning.
  function automatic logic is_illegal(input logic [7:0] op);
    logic bad_mode;
    bad_mode = (op[4:2] != 3'b001) && (op[4:2] != 3'b010) && (op[4:2] != 3'b011);
    return (op[1:0] != 2'b01) || (op[7:5] == 3'b111) || bad_mode || (op == 8'h89);
  endfunction

  assign bbb      = opcode_reg[4:2];
  assign is_sta   = (opcode_reg[7:5] == 3'b100);
  assign is_cmp   = (opcode_reg[7:5] == 3'b110);
  assign cmp_diff = a_reg - operand_reg;
  // Zero-page mode clears hi when lo is fetched, so one form serves both.
  assign eff_addr = {hi_reg, lo_reg};

  assign mem_req = run_reg && ((state_reg == FETCH_OP) || (state_reg == FETCH_LO) ||
                               (state_reg == FETCH_HI) || (state_reg == READ_OPND) ||
                               (state_reg == WRITE));
  assign xfer_done = mem_req && mem_ack;

  assign alu_operation = {opcode_reg[7:5], opcode_reg[1:0]};
  assign alu_operand1  = a_reg;
  assign alu_operand2  = operand_reg;
  assign alu_carry_in  = c_reg;

  assign reg_a  = a_reg;
  assign flag_c = c_reg;
  assign flag_z = z_reg;
  assign flag_n = n_reg;
  assign pc     = pc_reg;
  assign halted = (state_reg == HALT);

  // Next-state, bus drive and architectural updates; bus fields depend only
  // on registered state so they stay put while a transfer is waiting.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    a_next       = a_reg;
    opcode_next  = opcode_reg;
    operand_next = operand_reg;
    lo_next      = lo_reg;
    hi_next      = hi_reg;
    c_next       = c_reg;
    z_next       = z_reg;
    n_next       = n_reg;
    mem_addr     = pc_reg;
    mem_we       = 1'b0;
    mem_wdata    = 8'h00;

    case (state_reg)
      FETCH_OP: begin
        if (xfer_done) begin
          pc_next     = pc_reg + 16'd1;
          opcode_next = mem_rdata;
          state_next  = is_illegal(mem_rdata) ? HALT : FETCH_LO;
        end
      end
      FETCH_LO: begin
        if (xfer_done) begin
          pc_next = pc_reg + 16'd1;
          if (bbb == 3'b010) begin
            operand_next = mem_rdata;
            state_next   = EXECUTE;
          end else begin
            lo_next = mem_rdata;
            hi_next = 8'h00;
            if (bbb == 3'b011) begin
              state_next = FETCH_HI;
            end else begin
              state_next = is_sta ? WRITE : READ_OPND;
            end
          end
        end
      end
      FETCH_HI: begin
        if (xfer_done) begin
          pc_next    = pc_reg + 16'd1;
          hi_next    = mem_rdata;
          state_next = is_sta ? WRITE : READ_OPND;
        end
      end
      READ_OPND: begin
        mem_addr = eff_addr;
        if (xfer_done) begin
          operand_next = mem_rdata;
          state_next   = EXECUTE;
        end
      end
      EXECUTE: begin
        c_next = alu_carry_out;
        if (is_cmp) begin
          z_next = (a_reg == operand_reg);
          n_next = cmp_diff[7];
        end else begin
          a_next = alu_result;
          z_next = (alu_result == 8'h00);
          n_next = alu_result[7];
        end
        state_next = FETCH_OP;
      end
      WRITE: begin
        mem_addr  = eff_addr;
        mem_we    = 1'b1;
        mem_wdata = a_reg;
        if (xfer_done) begin
          state_next = FETCH_OP;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = FETCH_OP;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= FETCH_OP;
      run_reg     <= 1'b0;
      pc_reg      <= RESET_PC;
      a_reg       <= 8'h00;
      opcode_reg  <= 8'h00;
      operand_reg <= 8'h00;
      lo_reg      <= 8'h00;
      hi_reg      <= 8'h00;
      c_reg       <= 1'b0;
      z_reg       <= 1'b0;
      n_reg       <= 1'b0;
    end else begin
      state_reg   <= state_next;
      run_reg     <= 1'b1;
      pc_reg      <= pc_next;
      a_reg       <= a_next;
      opcode_reg  <= opcode_next;
      operand_reg <= operand_next;
      lo_reg      <= lo_next;
      hi_reg      <= hi_next;
      c_reg       <= c_next;
      z_reg       <= z_next;
      n_reg       <= n_next;
    end
  end

endmodule

// File: tb/tb_cpu6502_alu_sequencer.sv
// Bench for cpu6502_alu_sequencer: behavioural memory with programmable ack
// delay, a small external ALU model, and a scoreboard of expected memory
// transfers checked by an independent monitor.
module tb_cpu6502_alu_sequencer;

  localparam logic [15:0] RESET_PC = 16'h0200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [4:0]  alu_operation;
  logic [7:0]  alu_operand1, alu_operand2, alu_result;
  logic        alu_carry_in, alu_carry_out;
  logic [7:0]  reg_a;
  logic        flag_c, flag_z, flag_n, halted;
  logic [15:0] pc;

  always #5 clk = ~clk;

  cpu6502_alu_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .alu_operation(alu_operation), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_carry_in(alu_carry_in), .alu_result(alu_result), .alu_carry_out(alu_carry_out),
    .reg_a(reg_a), .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .pc(pc), .halted(halted)
  );

  // External ALU: logic ops and loads pass carry through, ADC adds with carry,
  // CMP carries when A >= operand.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum       = {1'b0, alu_operand1} + {1'b0, alu_operand2} + {8'd0, alu_carry_in};
    alu_result    = 8'h00;
    alu_carry_out = alu_carry_in;
    case (alu_operation[4:2])
      3'b000: alu_result = alu_operand1 | alu_operand2;
      3'b001: alu_result = alu_operand1 & alu_operand2;
      3'b010: alu_result = alu_operand1 ^ alu_operand2;
      3'b011: begin alu_result = alu_sum[7:0]; alu_carry_out = alu_sum[8]; end
      3'b101: alu_result = alu_operand2;
      3'b110: begin alu_result = alu_operand1 - alu_operand2; alu_carry_out = (alu_operand1 >= alu_operand2); end
      default: ;
    endcase
  end

  // Memory model: ack after ack_delay wait cycles; read data is junk outside ack.
  logic [7:0] mem [0:65535];
  int ack_delay = 0;
  int wait_cnt  = 0;
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'hEE;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          if (mem_we) mem[mem_addr] = mem_wdata;
          wait_cnt  = 0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 8'hEE;
          wait_cnt++;
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'hEE;
        wait_cnt  = 0;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    int          gap;
    logic        chk;
    logic [7:0]  a;
    logic        c, z, n;
  } txn_t;

  txn_t q[$];

  logic [7:0]  exp_a;
  logic        exp_c, exp_z, exp_n;
  logic [15:0] exp_pc;
  int          next_gap;
  logic        timing_chk;

  task automatic set_exp(input logic [7:0] a, input logic c, input logic z, input logic n);
    exp_a = a; exp_c = c; exp_z = z; exp_n = n;
  endtask

  task automatic push(input logic [15:0] addr, input logic we, input logic [7:0] wd,
                      input int gap, input logic chk);
    txn_t t;
    t.addr = addr; t.we = we; t.wdata = wd;
    t.gap = timing_chk ? gap : 0;
    t.chk = chk; t.a = exp_a; t.c = exp_c; t.z = exp_z; t.n = exp_n;
    q.push_back(t);
  endtask

  task automatic op_imm(input logic [7:0] na, input logic nc, input logic nz, input logic nn);
    push(exp_pc, 1'b0, 8'h00, next_gap, 1'b1);
    push(exp_pc + 16'd1, 1'b0, 8'h00, 1, 1'b0);
    exp_pc = exp_pc + 16'd2; next_gap = 2;
    set_exp(na, nc, nz, nn);
  endtask

  task automatic op_rd(input logic is_abs, input logic [15:0] ea, input logic [7:0] na,
                       input logic nc, input logic nz, input logic nn);
    push(exp_pc, 1'b0, 8'h00, next_gap, 1'b1);
    push(exp_pc + 16'd1, 1'b0, 8'h00, 1, 1'b0);
    if (is_abs) push(exp_pc + 16'd2, 1'b0, 8'h00, 1, 1'b0);
    push(ea, 1'b0, 8'h00, 1, 1'b0);
    exp_pc = exp_pc + (is_abs ? 16'd3 : 16'd2); next_gap = 2;
    set_exp(na, nc, nz, nn);
  endtask

  task automatic op_sta(input logic is_abs, input logic [15:0] ea);
    push(exp_pc, 1'b0, 8'h00, next_gap, 1'b1);
    push(exp_pc + 16'd1, 1'b0, 8'h00, 1, 1'b0);
    if (is_abs) push(exp_pc + 16'd2, 1'b0, 8'h00, 1, 1'b0);
    push(ea, 1'b1, exp_a, 1, 1'b0);
    exp_pc = exp_pc + (is_abs ? 16'd3 : 16'd2); next_gap = 1;
  endtask

  task automatic op_halt();
    push(exp_pc, 1'b0, 8'h00, next_gap, 1'b1);
    exp_pc = exp_pc + 16'd1; next_gap = 0;
  endtask

  task automatic put(input logic [15:0] addr, input logic [7:0] b);
    mem[addr] = b;
  endtask

  // Monitor: checks bus stability during waits and pops one expected entry
  // per completed transfer.
  int          cyc = 0;
  int          last_done = 0;
  logic        pending = 1'b0;
  logic [15:0] p_addr;
  logic        p_we;
  logic [7:0]  p_wd;
  initial begin
    txn_t t;
    forever begin
      @(negedge clk); #1;
      cyc++;
      if (mem_req === 1'b1) begin
        if (!pending) begin
          p_addr = mem_addr; p_we = mem_we; p_wd = mem_wdata; pending = 1'b1;
        end else begin
          check("bus_stable", {mem_addr, mem_we, mem_wdata}, {p_addr, p_we, p_wd});
        end
        if (mem_ack === 1'b1) begin
          pending = 1'b0;
          if (q.size() == 0) begin
            check("unexpected_xfer_addr", {15'd0, mem_we, mem_addr}, 32'hFFFF_FFFF);
          end else begin
            t = q.pop_front();
            check("xfer_addr", mem_addr, t.addr);
            check("xfer_we", mem_we, t.we);
            if (t.we) check("xfer_wdata", mem_wdata, t.wdata);
            if (t.gap != 0) check("xfer_gap", cyc - last_done, t.gap);
            if (t.chk) begin
              check("state_a", reg_a, t.a);
              check("state_czn", {flag_c, flag_z, flag_n}, {t.c, t.z, t.n});
              check("state_pc", pc, t.addr);
            end
          end
          last_done = cyc;
        end
      end else begin
        pending = 1'b0;
      end
    end
  end

  task automatic wait_halted(input int budget);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin @(negedge clk); #1; n++; end
    check("halt_reached", halted, 1'b1);
  endtask

  task automatic wait_req_addr(input logic [15:0] addr, input int budget);
    int n = 0;
    while (!(mem_req === 1'b1 && mem_addr === addr) && n < budget) begin @(negedge clk); #1; n++; end
    check("req_seen", {mem_req, mem_addr}, {1'b1, addr});
  endtask

  task automatic wait_q_empty(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin @(negedge clk); #1; n++; end
    check("queue_drained", q.size(), 0);
  endtask

  task automatic start_segment(input int delay, input logic tchk);
    reset = 1'b1;
    ack_delay = delay;
    timing_chk = tchk;
    repeat (3) @(negedge clk);
    set_exp(8'h00, 1'b0, 1'b0, 1'b0);
    exp_pc = RESET_PC;
    next_gap = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h02;

    // Reset state
    start_segment(0, 1'b1);
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_wdata", mem_wdata, 8'h00);
    check("rst_pc", pc, RESET_PC);
    check("rst_a", reg_a, 8'h00);
    check("rst_czn", {flag_c, flag_z, flag_n}, 3'b000);
    check("rst_halted", halted, 1'b0);
    check("rst_alu_op", {alu_operation, alu_operand2}, 13'd0);

    // Zero-wait program: immediates, STA abs, ADC abs, STA zp, CMP, halt
    put(16'h0200, 8'hA9); put(16'h0201, 8'h5A);
    put(16'h0202, 8'hA9); put(16'h0203, 8'h01);
    put(16'h0204, 8'h69); put(16'h0205, 8'hFF);
    put(16'h0206, 8'hA9); put(16'h0207, 8'h77);
    put(16'h0208, 8'h8D); put(16'h0209, 8'h34); put(16'h020A, 8'h12);
    put(16'h020B, 8'h6D); put(16'h020C, 8'h34); put(16'h020D, 8'h12);
    put(16'h020E, 8'h29); put(16'h020F, 8'h0F);
    put(16'h0210, 8'h49); put(16'h0211, 8'hFF);
    put(16'h0212, 8'h85); put(16'h0213, 8'h40);
    put(16'h0214, 8'hA9); put(16'h0215, 8'h7F);
    put(16'h0216, 8'hC9); put(16'h0217, 8'h80);
    put(16'h0218, 8'hE9);
    op_imm(8'h5A, 1'b0, 1'b0, 1'b0);
    op_imm(8'h01, 1'b0, 1'b0, 1'b0);
    op_imm(8'h00, 1'b1, 1'b1, 1'b0);
    op_imm(8'h77, 1'b1, 1'b0, 1'b0);
    op_sta(1'b1, 16'h1234);
    op_rd(1'b1, 16'h1234, 8'hEF, 1'b0, 1'b0, 1'b1);
    op_imm(8'h0F, 1'b0, 1'b0, 1'b0);
    op_imm(8'hF0, 1'b0, 1'b0, 1'b1);
    op_sta(1'b0, 16'h0040);
    op_imm(8'h7F, 1'b0, 1'b0, 1'b0);
    op_imm(8'h7F, 1'b0, 1'b0, 1'b1);
    op_halt();
    @(negedge clk); reset = 1'b0;
    wait_halted(300);
    check("seg1_queue", q.size(), 0);
    check("seg1_halt_pc", pc, 16'h0219);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check("halt_hold", {halted, mem_req}, 2'b10);
    end
    check("seg1_final_a", reg_a, 8'h7F);
    check("seg1_final_czn", {flag_c, flag_z, flag_n}, 3'b001);

    // Three-cycle ack delay: LDA zp, A changes only after the operand ack
    start_segment(3, 1'b0);
    put(16'h0200, 8'hA5); put(16'h0201, 8'h10); put(16'h0202, 8'h02);
    put(16'h0010, 8'h3C);
    op_rd(1'b0, 16'h0010, 8'h3C, 1'b0, 1'b0, 1'b0);
    op_halt();
    @(negedge clk); reset = 1'b0;
    wait_req_addr(16'h0010, 100);
    check("zp_wait_a", reg_a, 8'h00);
    repeat (3) begin @(negedge clk); #1; end
    check("zp_ack_cycle", {mem_ack, reg_a}, {1'b1, 8'h00});
    @(negedge clk); #1;
    check("zp_exec_cycle", {mem_req, reg_a}, {1'b0, 8'h00});
    @(negedge clk); #1;
    check("zp_after_exec_a", reg_a, 8'h3C);
    wait_halted(200);
    check("seg2_queue", q.size(), 0);
    check("seg2_halt_pc", pc, 16'h0203);

    // Reset while waiting on the FETCH_HI of LDA abs
    start_segment(5, 1'b0);
    put(16'h0200, 8'hA9); put(16'h0201, 8'h5A);
    put(16'h0202, 8'hAD); put(16'h0203, 8'h00); put(16'h0204, 8'h30);
    op_imm(8'h5A, 1'b0, 1'b0, 1'b0);
    push(16'h0202, 1'b0, 8'h00, 0, 1'b1);
    push(16'h0203, 1'b0, 8'h00, 0, 1'b0);
    @(negedge clk); reset = 1'b0;
    wait_req_addr(16'h0204, 200);
    check("pre_reset_a", reg_a, 8'h5A);
    reset = 1'b1;
    @(negedge clk); #1;
    check("req_after_reset", mem_req, 1'b0);
    check("seg3_queue", q.size(), 0);
    reset = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk); #1;
    check("first_req_after_release", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, RESET_PC});
    check("a_after_release", reg_a, 8'h00);
    set_exp(8'h00, 1'b0, 1'b0, 1'b0);
    push(RESET_PC, 1'b0, 8'h00, 0, 1'b1);
    wait_q_empty(100);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
